// File: rtl/cache_refill_responder_pkg.sv
// Shared constants, FSM encodings and address-split helpers for the refill responder and cache side.
// Optional build macro: REFILL_CRIT_WORD_FIRST_EN (critical-word-first beat order).
package cache_refill_responder_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int MEM_LINES  = 64;
  localparam int OFFSET_W   = 3;
  localparam int INDEX_W    = 6;
  localparam int MEM_AW     = INDEX_W + OFFSET_W;
  localparam int CNT_W      = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  function automatic logic [OFFSET_W-1:0] word_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W+1:2];
  endfunction

  // Upper address bits fold onto the backing store (modulo MEM_LINES).
  function automatic logic [INDEX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  endfunction

endpackage

// File: rtl/cache_refill_responder_if.sv
// Refill request/response and preload bus between cache fill logic and the responder.
// Optional build macro: REFILL_CRIT_WORD_FIRST_EN (affects responder beat order only).
interface cache_refill_responder_if;
  import cache_refill_responder_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic                rsp_valid;
  logic [WORD_W-1:0]   rsp_data;
  logic [OFFSET_W-1:0] rsp_word;
  logic                rsp_last;
  logic                busy;
  logic                ld_en;
  logic [ADDR_W-1:0]   ld_addr;
  logic [WORD_W-1:0]   ld_data;

  modport slave (
    input  req_valid, req_addr, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_word, rsp_last, busy
  );

  modport master (
    output req_valid, req_addr, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_word, rsp_last, busy
  );

endinterface

// File: rtl/cache_refill_responder_mem_array.sv
// Backing store: one sync write port (preload), one sync read port (beat fetch), read-before-write.
// Optional build macro: REFILL_CRIT_WORD_FIRST_EN (not used here).
module refill_mem_array
  import cache_refill_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [MEM_AW-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_r [MEM_LINES*LINE_WORDS];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the registered beat data output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= {WORD_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/cache_refill_responder.sv
// Memory-side line refill responder: accept, wait LATENCY cycles, stream 8 beats.
// Optional build macro: REFILL_CRIT_WORD_FIRST_EN (start at requested word, wrap 7->0).
module cache_refill_responder
  import cache_refill_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  cache_refill_responder_if.slave bus
);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [OFFSET_W-1:0] beat_r;
  logic [OFFSET_W-1:0] word_s;
  logic [INDEX_W-1:0]  index_r;
  logic                accept_s;
  logic                req_ready_r;
  logic                rsp_valid_r;
  logic                rsp_last_r;
  logic                busy_r;
  logic [OFFSET_W-1:0] rsp_word_r;
  logic [WORD_W-1:0]   rd_data_s;

  assign accept_s = bus.req_valid && req_ready_r && (state_r == ST_IDLE);

`ifdef REFILL_CRIT_WORD_FIRST_EN
  logic [OFFSET_W-1:0] start_r;

  // Start offset of the burst, latched on accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_r <= {OFFSET_W{1'b0}};
    end else if (accept_s) begin
      start_r <= word_offset(bus.req_addr);
    end
  end

  assign word_s = start_r + beat_r;
`else
  assign word_s = beat_r;
`endif

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (LATENCY > 0) ? ST_WAIT : ST_BURST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_nxt_s = ST_BURST;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_BURST: begin
        if (beat_r == 3'd7) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; ready returns one cycle after the last beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      beat_r      <= {OFFSET_W{1'b0}};
      index_r     <= {INDEX_W{1'b0}};
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_word_r  <= {OFFSET_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      req_ready_r <= (state_r == ST_IDLE) && (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_r == ST_BURST);
      rsp_last_r  <= (state_r == ST_BURST) && (beat_r == 3'd7);
      if (state_r == ST_BURST) begin
        rsp_word_r <= word_s;
      end
      if (accept_s) begin
        index_r <= line_index(bus.req_addr);
        cnt_r   <= CNT_W'(LATENCY);
        beat_r  <= {OFFSET_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else if (state_r == ST_BURST) begin
        beat_r <= beat_r + 3'd1;
      end
    end
  end

  refill_mem_array u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.ld_en),
    .wr_addr ({line_index(bus.ld_addr), word_offset(bus.ld_addr)}),
    .wr_data (bus.ld_data),
    .rd_en   (state_r == ST_BURST),
    .rd_addr ({index_r, word_s}),
    .rd_data (rd_data_s)
  );

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rd_data_s;
  assign bus.rsp_word  = rsp_word_r;
  assign bus.rsp_last  = rsp_last_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_cache_refill_responder.sv
// Directed bench for cache_refill_responder: a LATENCY=4 and a LATENCY=0 instance share one memory model.
// Beat order expectations follow REFILL_CRIT_WORD_FIRST_EN when it is defined.
module tb_cache_refill_responder;

`ifdef REFILL_CRIT_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [512];

  always #5 clk = ~clk;

  cache_refill_responder_if b4 ();
  cache_refill_responder_if b0 ();

  cache_refill_responder #(.LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  cache_refill_responder #(.LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

  logic        o_valid, o_last, o_ready, o_busy;
  logic [31:0] o_data;
  logic [2:0]  o_word;
  assign o_valid = sel ? b0.rsp_valid : b4.rsp_valid;
  assign o_last  = sel ? b0.rsp_last  : b4.rsp_last;
  assign o_ready = sel ? b0.req_ready : b4.req_ready;
  assign o_busy  = sel ? b0.busy      : b4.busy;
  assign o_data  = sel ? b0.rsp_data  : b4.rsp_data;
  assign o_word  = sel ? b0.rsp_word  : b4.rsp_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ld(input logic en, input logic [31:0] addr, input logic [31:0] data);
    b4.ld_en = en; b4.ld_addr = addr; b4.ld_data = data;
    b0.ld_en = en; b0.ld_addr = addr; b0.ld_data = data;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    drive_ld(1'b1, addr, data);
    tick();
    drive_ld(1'b0, 32'h0, 32'h0);
    model[{addr[10:5], addr[4:2]}] = data;
  endtask

  task automatic issue(input logic s, input logic [31:0] addr);
    sel = s;
    if (s) begin
      b0.req_valid = 1'b1; b0.req_addr = addr;
    end else begin
      b4.req_valid = 1'b1; b4.req_addr = addr;
    end
    tick();
    b0.req_valid = 1'b0;
    b4.req_valid = 1'b0;
  endtask

  // Called just after the accept edge; inj_k>0 writes word of beat inj_k while it is being fetched,
  // rst_k>=0 pulls reset while beat rst_k is on the bus.
  task automatic burst(input logic s, input logic [31:0] addr, input int lat,
                       input int inj_k, input logic [31:0] inj_data, input int rst_k);
    int n;
    int cnt;
    logic [2:0] start;
    logic [2:0] w;
    logic [2:0] wn;
    logic [8:0] idx;
    sel = s;
    start = addr[4:2];
    check_eq("accept busy", 32'(o_busy), 32'd1);
    check_eq("accept ready", 32'(o_ready), 32'd0);
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq("first beat latency", 32'(n), 32'(lat + 1));
    if (!o_valid) return;
    for (int k = 0; k < 8; k++) begin
      w = CRIT ? 3'(start + 3'(k)) : 3'(k);
      idx = {addr[10:5], w};
      check_eq("beat valid", 32'(o_valid), 32'd1);
      check_eq("beat word", 32'(o_word), 32'(w));
      check_eq("beat data", o_data, model[idx]);
      check_eq("beat last", 32'(o_last), 32'(k == 7));
      check_eq("beat ready", 32'(o_ready), 32'd0);
      if (k == inj_k) model[idx] = inj_data;
      if (k == rst_k) begin
        reset = 1'b0;
        tick();
        check_eq("abort valid", 32'(o_valid), 32'd0);
        check_eq("abort last", 32'(o_last), 32'd0);
        check_eq("abort busy", 32'(o_busy), 32'd0);
        check_eq("abort ready", 32'(o_ready), 32'd1);
        reset = 1'b1;
        cnt = 0;
        for (int j = 0; j < 6; j++) begin
          tick();
          if (o_valid) cnt++;
        end
        check_eq("abort no beats", 32'(cnt), 32'd0);
        return;
      end
      if (k + 1 == inj_k) begin
        wn = CRIT ? 3'(start + 3'(k + 1)) : 3'(k + 1);
        drive_ld(1'b1, {addr[31:5], wn, 2'b00}, inj_data);
        tick();
        drive_ld(1'b0, 32'h0, 32'h0);
      end else begin
        tick();
      end
    end
    check_eq("end valid", 32'(o_valid), 32'd0);
    check_eq("end ready", 32'(o_ready), 32'd1);
    check_eq("end busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    reset = 1'b0;
    b4.req_valid = 1'b0; b4.req_addr = 32'h0;
    b0.req_valid = 1'b0; b0.req_addr = 32'h0;
    drive_ld(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 512; i++) model[i] = 32'h0;
    tick();
    tick();
    check_eq("rst ready", 32'(b4.req_ready), 32'd1);
    check_eq("rst valid", 32'(b4.rsp_valid), 32'd0);
    check_eq("rst data", b4.rsp_data, 32'h0);
    check_eq("rst word", 32'(b4.rsp_word), 32'd0);
    check_eq("rst last", 32'(b4.rsp_last), 32'd0);
    check_eq("rst busy", 32'(b4.busy), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      preload(32'h0000_0060 + 32'(4 * i), 32'h3000_0000 + 32'(i));
      preload(32'h0000_0040 + 32'(4 * i), 32'h2000_0000 + 32'(i));
    end

    // Plain line refill, then a mid-line request address.
    issue(1'b0, 32'h0000_0060);
    burst(1'b0, 32'h0000_0060, 4, -1, 32'h0, -1);
    issue(1'b0, 32'h0000_0074);
    burst(1'b0, 32'h0000_0074, 4, -1, 32'h0, -1);

    // req_valid held high across two requests.
    sel = 1'b0;
    b4.req_valid = 1'b1;
    b4.req_addr = 32'h0000_0060;
    tick();
    b4.req_addr = 32'h0000_0040;
    burst(1'b0, 32'h0000_0060, 4, -1, 32'h0, -1);
    tick();
    b4.req_valid = 1'b0;
    burst(1'b0, 32'h0000_0040, 4, -1, 32'h0, -1);

    // Reset during beat 3, memory retained.
    issue(1'b0, 32'h0000_0060);
    burst(1'b0, 32'h0000_0060, 4, -1, 32'h0, 3);
    issue(1'b0, 32'h0000_0060);
    burst(1'b0, 32'h0000_0060, 4, -1, 32'h0, -1);

    // Preload collides with the fetch of beat 2.
    issue(1'b0, 32'h0000_0060);
    burst(1'b0, 32'h0000_0060, 4, 2, 32'hDEAD_0002, -1);
    issue(1'b0, 32'h0000_0060);
    burst(1'b0, 32'h0000_0060, 4, -1, 32'h0, -1);

    // Zero-latency instance, upper address bits fold onto line 3.
    issue(1'b1, 32'hFFFF_F860);
    burst(1'b1, 32'hFFFF_F860, 0, -1, 32'h0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
